// File: rtl/mtl1_pkg.sv
// Shared types and constants for the 6809 SPI flash window.
package mtl1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [7:0]  SPI_CMD_READ   = 8'h03;
  localparam int          SPI_FRAME_BITS = 40;
  localparam int          SPI_DATA_BITS  = 8;
  localparam logic [15:0] FLASH_WIN_BASE = 16'h3000;

  // Byte offset within the 4 KiB CPU window, added modulo 2^24 to the flash base.
  function automatic logic [23:0] flash_offset(input logic [23:0] base,
                                               input logic [15:0] addr);
    logic [15:0] win_off;
    win_off = (addr - FLASH_WIN_BASE) & 16'h0FFF;
    return base + {8'h00, win_off};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI READ engine: one byte per CPU access to the flash window, stretching the
// CPU cycle via o_ready and yielding the pads whenever the FT2232 owns the flash.
module spi_flash_reader
  import mtl1_pkg::*;
#(
  parameter int          CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter logic [7:0]  CMD_READ   = SPI_CMD_READ
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_spi_ce,
  input  logic [15:0] i_address,
  input  logic        i_FT_CS,
  output logic [7:0]  o_data,
  output logic        o_ready,
  output logic        o_abort,
  output logic        o_spi_oe,
  output logic        o_spi_cs_n,
  output logic        o_spi_sck,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]        BIT_LAST = 6'(SPI_FRAME_BITS - 1);
  localparam logic [5:0]        RX_FIRST = 6'(SPI_FRAME_BITS - SPI_DATA_BITS);

  logic [1:0] sync_q;
  logic       ce_s;
  logic       ft_s;
  logic       ce_d;

  state_t                    state;
  state_t                    state_nxt;
  logic [DIV_W-1:0]          div_cnt;
  logic [5:0]                bit_cnt;
  logic [SPI_FRAME_BITS-1:0] tx;
  logic [SPI_DATA_BITS-1:0]  rx;
  logic [SPI_FRAME_BITS-1:0] frame;

  logic start;
  logic abort_now;
  logic div_last;
  logic sck_rise;
  logic sck_fall;

  sync_2ff #(.WIDTH(2)) u_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     ({i_spi_ce, i_FT_CS}),
    .q     (sync_q)
  );

  assign ce_s       = sync_q[1];
  assign ft_s       = sync_q[0];
  assign o_spi_mosi = tx[SPI_FRAME_BITS-1];

  always_comb begin
    start     = (state == ST_IDLE) && ce_s && !ce_d && ft_s;
    abort_now = !ft_s && ((state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD));
    div_last  = (div_cnt == DIV_LAST);
    sck_rise  = (state == ST_SHIFT) && div_last && !o_spi_sck;
    sck_fall  = (state == ST_SHIFT) && div_last && o_spi_sck;
    frame     = {CMD_READ, flash_offset(FLASH_BASE, i_address), {SPI_DATA_BITS{1'b0}}};

    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SETUP;
      ST_SETUP: if (abort_now) state_nxt = ST_DONE;
                else if (div_last) state_nxt = ST_SHIFT;
      ST_SHIFT: if (abort_now) state_nxt = ST_DONE;
                else if (sck_fall && (bit_cnt == BIT_LAST)) state_nxt = ST_HOLD;
      ST_HOLD:  if (abort_now || div_last) state_nxt = ST_DONE;
      ST_DONE:  if (!ce_s) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ce_d       <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      o_data     <= 8'hFF;
      o_ready    <= 1'b1;
      o_abort    <= 1'b0;
      o_spi_oe   <= 1'b0;
      o_spi_cs_n <= 1'b1;
      o_spi_sck  <= 1'b0;
    end else begin
      ce_d     <= ce_s;
      o_spi_oe <= ft_s;

      if ((state == ST_SETUP || state == ST_SHIFT || state == ST_HOLD) && !div_last)
        div_cnt <= div_cnt + DIV_W'(1);
      else
        div_cnt <= '0;

      // The FT2232 taking the bus wins over any phase of a transfer in flight.
      if (abort_now) begin
        tx         <= '0;
        o_spi_cs_n <= 1'b1;
        o_spi_sck  <= 1'b0;
        o_data     <= 8'hFF;
        o_abort    <= 1'b1;
        o_ready    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            tx         <= frame;
            bit_cnt    <= '0;
            o_ready    <= 1'b0;
            o_abort    <= 1'b0;
            o_spi_cs_n <= 1'b0;
          end
          ST_SHIFT: if (div_last) begin
            o_spi_sck <= ~o_spi_sck;
            if (o_spi_sck) begin
              tx      <= tx << 1;
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          ST_HOLD: if (div_last) begin
            o_spi_cs_n <= 1'b1;
            o_ready    <= 1'b1;
            o_data     <= rx;
          end
          default: ;
        endcase
      end
    end
  end

  // Only the last SPI_DATA_BITS periods carry flash data; earlier MISO is don't-care.
  always_ff @(posedge i_clk) begin
    if (sck_rise && (bit_cnt >= RX_FIRST))
      rx <= {rx[SPI_DATA_BITS-2:0], i_spi_miso};
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural SPI flash model.
module tb_spi_flash_reader;

  localparam int          CLK_DIV = 2;
  localparam logic [23:0] BASE    = 24'hFFF800;
  localparam int          XFER_CYCLES = CLK_DIV * (1 + 80 + 1);

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_spi_ce = 1'b0;
  logic [15:0] i_address = 16'h0000;
  logic        i_FT_CS = 1'b1;
  logic [7:0]  o_data;
  logic        o_ready;
  logic        o_abort;
  logic        o_spi_oe;
  logic        o_spi_cs_n;
  logic        o_spi_sck;
  logic        o_spi_mosi;
  logic        i_spi_miso = 1'b0;

  int errors = 0;
  int checks = 0;

  spi_flash_reader #(
    .CLK_DIV    (CLK_DIV),
    .FLASH_BASE (BASE),
    .CMD_READ   (8'h03)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_spi_ce   (i_spi_ce),
    .i_address  (i_address),
    .i_FT_CS    (i_FT_CS),
    .o_data     (o_data),
    .o_ready    (o_ready),
    .o_abort    (o_abort),
    .o_spi_oe   (o_spi_oe),
    .o_spi_cs_n (o_spi_cs_n),
    .o_spi_sck  (o_spi_sck),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso)
  );

  always #5 i_clk = ~i_clk;

  // Flash model: mode 0, captures MOSI on SCK rise, drives the response byte after 32 bits.
  logic [39:0] fl_frame = '0;
  int          fl_cnt = 0;
  logic [7:0]  fl_resp = 8'h00;
  logic        prev_sck = 1'b0;
  logic        prev_cs = 1'b1;

  always @(negedge i_clk) begin
    if (prev_cs && !o_spi_cs_n) begin
      fl_cnt   = 0;
      fl_frame = '0;
    end
    if (!o_spi_cs_n && !prev_sck && o_spi_sck) begin
      fl_frame = {fl_frame[38:0], o_spi_mosi};
      fl_cnt++;
    end
    if (!o_spi_cs_n && prev_sck && !o_spi_sck && fl_cnt >= 32 && fl_cnt < 40)
      i_spi_miso = fl_resp[39 - fl_cnt];
    prev_sck = o_spi_sck;
    prev_cs  = o_spi_cs_n;
  end

  function automatic logic [39:0] model_frame(input logic [15:0] addr);
    longint unsigned a;
    a = (longint'(BASE) + longint'(addr % 16'd4096)) % 64'd16777216;
    return {8'h03, a[23:0], 8'h00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"},  64'(o_data),     64'hFF);
    check({tag, "_ready"}, 64'(o_ready),    64'd1);
    check({tag, "_abort"}, 64'(o_abort),    64'd0);
    check({tag, "_oe"},    64'(o_spi_oe),   64'd0);
    check({tag, "_cs_n"},  64'(o_spi_cs_n), 64'd1);
    check({tag, "_sck"},   64'(o_spi_sck),  64'd0);
    check({tag, "_mosi"},  64'(o_spi_mosi), 64'd0);
  endtask

  task automatic wait_ready(input logic val, input int bound, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < bound) begin
      @(posedge i_clk); #1;
      cycles++;
      if (o_ready === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bits(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge i_clk); #1;
      if (fl_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] resp,
                         input logic [39:0] exp_frame);
    int cyc;
    bit ok;
    bit cs_ok;
    fl_resp = resp;
    @(negedge i_clk);
    i_address = addr;
    i_spi_ce  = 1'b1;
    wait_ready(1'b0, 20, cyc, ok);
    if (!ok) begin
      timeout({tag, "_start"});
      @(negedge i_clk) i_spi_ce = 1'b0;
      return;
    end
    check({tag, "_start_lat"}, 64'(cyc), 64'd3);
    cs_ok = !o_spi_cs_n;
    cyc = 0;
    while (!o_ready && cyc < 1000) begin
      @(posedge i_clk); #1;
      cyc++;
      if (!o_ready && o_spi_cs_n) cs_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(XFER_CYCLES));
    check({tag, "_data"},    64'(o_data), 64'(resp));
    check({tag, "_frame"},   64'(fl_frame), 64'(exp_frame));
    check({tag, "_bits"},    64'(fl_cnt), 64'd40);
    check({tag, "_cs_low"},  64'(cs_ok), 64'd1);
    check({tag, "_abort"},   64'(o_abort), 64'd0);
    @(negedge i_clk) i_spi_ce = 1'b0;
    repeat (4) @(posedge i_clk);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  resp;
    logic [39:0] frame;
  } vec_t;

  vec_t vt[5];

  initial begin
    int cyc;
    bit ok;
    bit flag;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic [7:0]  last_data;

    vt[0] = '{16'h3000, 8'hA5, 40'h03FFF80000};
    vt[1] = '{16'h3FFF, 8'h3C, 40'h030007FF00};
    vt[2] = '{16'h37FF, 8'h81, 40'h03FFFFFF00};
    vt[3] = '{16'h3800, 8'h7E, 40'h0300000000};
    vt[4] = '{16'h3010, 8'h5A, 40'h03FFF81000};

    repeat (3) @(posedge i_clk);
    #1 check_reset_vals("reset");
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (5) @(posedge i_clk);
    #1 check("oe_owned", 64'(o_spi_oe), 64'd1);

    for (int i = 0; i < 5; i++)
      do_read($sformatf("vec%0d", i), vt[i].addr, vt[i].resp, vt[i].frame);

    for (int i = 0; i < 6; i++) begin
      ra = 16'h3000 + 16'($urandom_range(0, 4095));
      rd = 8'($urandom_range(0, 255));
      do_read($sformatf("rnd%0d", i), ra, rd, model_frame(ra));
    end
    last_data = rd;

    // FT2232 owns the flash: a ce pulse must not start anything.
    @(negedge i_clk) i_FT_CS = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 check("ft_oe_off", 64'(o_spi_oe), 64'd0);
    flag = 1'b1;
    @(negedge i_clk) begin i_address = 16'h3123; i_spi_ce = 1'b1; end
    for (int i = 0; i < 12; i++) begin
      @(posedge i_clk); #1;
      if (!o_ready || !o_spi_cs_n || o_spi_sck) flag = 1'b0;
    end
    @(negedge i_clk) i_spi_ce = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    check("ft_idle_quiet", 64'(flag), 64'd1);
    check("ft_data_kept", 64'(o_data), 64'(last_data));
    @(negedge i_clk) i_FT_CS = 1'b1;
    repeat (5) @(posedge i_clk);

    // Abort during SCK period 20.
    fl_resp = 8'h99;
    @(negedge i_clk) begin i_address = 16'h3000; i_spi_ce = 1'b1; end
    wait_bits(21, 2000, ok);
    if (!ok) timeout("abort_wait");
    @(negedge i_clk) i_FT_CS = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 check("abort_not_early", 64'(o_spi_cs_n), 64'd0);
    @(posedge i_clk); #1;
    check("abort_cs_n",  64'(o_spi_cs_n), 64'd1);
    check("abort_oe",    64'(o_spi_oe),   64'd0);
    check("abort_sck",   64'(o_spi_sck),  64'd0);
    check("abort_data",  64'(o_data),     64'hFF);
    check("abort_flag",  64'(o_abort),    64'd1);
    check("abort_ready", 64'(o_ready),    64'd1);
    @(negedge i_clk) begin i_FT_CS = 1'b1; i_spi_ce = 1'b0; end
    repeat (6) @(posedge i_clk);
    #1 check("abort_sticky", 64'(o_abort), 64'd1);
    do_read("post_abort", 16'h3FFF, 8'h3C, 40'h030007FF00);

    // Asynchronous reset in the middle of SHIFT.
    fl_resp = 8'hE7;
    @(negedge i_clk) begin i_address = 16'h3456; i_spi_ce = 1'b1; end
    wait_bits(10, 2000, ok);
    if (!ok) timeout("rst_wait");
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge i_clk) i_spi_ce = 1'b0;
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (6) @(posedge i_clk);
    do_read("post_rst", 16'h3010, 8'h5A, 40'h03FFF81000);

    // ce drops at period 10, second ce pulse during the transfer is ignored.
    fl_resp = 8'hC3;
    @(negedge i_clk) begin i_address = 16'h3ABC; i_spi_ce = 1'b1; end
    wait_ready(1'b0, 20, cyc, ok);
    if (!ok) timeout("cedrop_start");
    wait_bits(10, 2000, ok);
    if (!ok) timeout("cedrop_wait");
    @(negedge i_clk) i_spi_ce = 1'b0;
    wait_bits(15, 2000, ok);
    @(negedge i_clk) i_spi_ce = 1'b1;
    repeat (6) @(posedge i_clk);
    @(negedge i_clk) i_spi_ce = 1'b0;
    wait_ready(1'b1, 1000, cyc, ok);
    if (!ok) timeout("cedrop_done");
    check("cedrop_data",  64'(o_data),   64'hC3);
    check("cedrop_frame", 64'(fl_frame), 64'(model_frame(16'h3ABC)));
    check("cedrop_bits",  64'(fl_cnt),   64'd40);
    do_read("after_cedrop", 16'h3000, 8'hA5, 40'h03FFF80000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

Read engine between the address decoder's `spi_ce` output and the external SPI flash. When the 6809 accesses the flash window (0x3000–0x3FFF), the block:
- issues a standard READ (0x03) with a 24-bit address,
- shifts in one byte,
- stretches the CPU cycle via `o_ready` until the data is valid.

It releases the SPI pins whenever the FT2232 owns the flash (`i_FT_CS` low).

## Interface
Parameters:
- `CLK_DIV`, 2: i_clk cycles per SCK half-period (≥1).
- `FLASH_BASE`, 24'h000000: flash byte offset mapped to CPU address 0x3000.
- `CMD_READ`, 8'h03: SPI read opcode.

Ports:
- `i_clk`  in  1  system clock, single clock domain.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_spi_ce`  in  1  chip enable from the address decoder; asynchronous to i_clk.
- `i_address`  in  16  6809 address bus; sampled at start.
- `i_FT_CS`  in  1  FT2232 flash chip select; low means the FT2232 owns the flash. Asynchronous.
- `o_data`  out  8  last byte read.
- `o_ready`  out  1  high = CPU may complete the cycle; low = stretch.
- `o_abort`  out  1  sticky until next start; last transfer was aborted by the FT2232.
- `o_spi_oe`  out  1  drive enable for CS_n/SCK/MOSI pads.
- `o_spi_cs_n`  out  1  flash chip select.
- `o_spi_sck`  out  1  SPI clock, mode 0.
- `o_spi_mosi`  out  1  serial out.
- `i_spi_miso`  in  1  serial in.

## Operation
Input handling:
- `i_spi_ce` and `i_FT_CS` each pass through a 2-flop synchronizer.
- Start = rising edge of synchronized ce (`ce_s` & ~`ce_d`) while in IDLE and synchronized FT_CS = 1.

States and transitions:
- **IDLE**: cs_n=1, sck=0, ready=1.
  - On start: latch `tx = {CMD_READ, FLASH_BASE + {12'h000, i_address[11:0]}}` (40 bits). The add is 24-bit, modulo 2^24 (wraps).
  - Set ready=0, clear o_abort, go to SETUP.
- **SETUP**: cs_n=0 for CLK_DIV cycles, MOSI = tx[39]; then go to SHIFT.
- **SHIFT**: 40 SCK periods, 6-bit counter 0..39.
  - SCK rises after CLK_DIV cycles low and falls after CLK_DIV cycles high.
  - On each falling edge, MOSI shifts to the next bit, MSB first.
  - On each rising edge during periods 32..39, MISO is shifted into rx, MSB first.
  - After the 40th falling edge, go to HOLD.
- **HOLD**: sck=0, cs_n=0 for CLK_DIV cycles. Then cs_n=1, o_data<=rx, ready=1, and go to DONE.
- **DONE**: wait for synchronized ce = 0, then go to IDLE. If ce is already 0 on entry, go to IDLE on the next cycle.

Pad ownership and abort:
- `o_spi_oe` = synchronized FT_CS, registered, in every state.
- If FT_CS_s falls in SETUP, SHIFT, or HOLD:
  - Immediately: cs_n=1, sck=0, oe=0.
  - Set o_data=8'hFF and o_abort=1, ready=1, go to DONE.
- In IDLE with FT_CS_s=0, starts are ignored and ready stays 1.

Other boundary cases:
- A ce rising edge while not in IDLE is ignored.
- ce falling mid-transfer does not abort the transfer. It completes and o_data updates.
- Reset mid-transfer forces all outputs to their reset values asynchronously. No partial data is retained.

## Timing
Reset values:
- o_data=8'hFF, o_ready=1, o_abort=0
- o_spi_oe=0, o_spi_cs_n=1, o_spi_sck=0, o_spi_mosi=0

Latency and timing:
- Start detection: 2 sync cycles + 1 edge-detect cycle after ce rises.
- Start to ready high: `CLK_DIV*(1 + 80 + 1)` cycles. For CLK_DIV=2 this is 164 cycles.
- SCK period = 2*CLK_DIV cycles, 50% duty.
- MOSI is stable ≥ CLK_DIV cycles before each rising edge.
- o_data is valid the same cycle o_ready rises and is held until the next completed transfer.
- Abort response: 1 cycle after FT_CS_s falls.

## Structure
Shared package `mtl1_pkg` holds:
- the state enum (IDLE, SETUP, SHIFT, HOLD, DONE),
- `SPI_CMD_READ`, `SPI_FRAME_BITS`=40, `SPI_DATA_BITS`=8,
- `FLASH_WIN_BASE`=16'h3000.

Sub-module `sync_2ff` (parameterized width) synchronizes `i_spi_ce` and `i_FT_CS`. The FSM, SCK divider and shift registers stay in the top module.

## Test plan
- Read at 0x3000, FLASH_BASE=0, flash model returns 0xA5:
  - MOSI frame is 0x03_000000.
  - o_data=0xA5, ready low for 164 cycles (CLK_DIV=2), cs_n low for the whole frame.
- Read at 0x3FFF with FLASH_BASE=24'hFFF800:
  - Address sent is 24'h0007FF (wrap).
  - Data 0x3C is captured correctly.
- i_FT_CS low, then ce pulse:
  - No transfer, oe=0, ready stays 1, o_data unchanged.
- i_FT_CS falls during SCK period 20:
  - Next cycle: cs_n=1, oe=0, o_data=0xFF, o_abort=1, ready=1.
  - The next normal read clears o_abort.
- i_rst_n asserted during SHIFT:
  - All outputs go to reset values immediately.
  - After release, a read of 0x3010 returning 0x5A succeeds.
- ce deasserts at period 10:
  - Transfer completes, o_data updates, FSM returns to IDLE without waiting in DONE.
  - A second ce pulse during the transfer is ignored.
